// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared widths, sequencer state encoding and address range check
package mem_responder_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  function automatic logic in_range(input logic [ADDR_W_DEF-1:0] a, input int unsigned depth_log2);
    return (a >> depth_log2) == '0;
  endfunction
endpackage

// File: rtl/mem_responder_resp_ram.sv
// resp_ram: single-port synchronous RAM with write enable and registered read
module resp_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
    if (re) q <= mem[a];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: burst memory responder with wait states, response pulses and range checking
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        burst,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              wack,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] WL = 3'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  localparam state_t FIRST = WAIT_CYCLES == 0 ? ACCESS : WAIT;
  state_t state;
  logic [2:0] cnt;
  logic [3:0] beats;
  logic [ADDR_W-1:0] a;
  logic dir, acc_err, oor_q, oor, access;
  logic [DATA_W-1:0] q;
  assign oor = !in_range(a, DEPTH_LOG2);
  assign access = state == ACCESS;
  assign ready = state == IDLE;
  assign wack = access && dir;
  // oor_q remembers whether the last read beat missed the RAM, so rdata holds as zero
  assign rdata = oor_q ? '0 : q;
  resp_ram #(.AW(DEPTH_LOG2), .DW(DATA_W)) u_ram (
    .clk(clk),
    .we(access && dir && !oor),
    .re(access && !dir),
    .a(a[DEPTH_LOG2-1:0]),
    .d(wdata),
    .q(q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      beats   <= '0;
      a       <= '0;
      dir     <= 1'b0;
      acc_err <= 1'b0;
      oor_q   <= 1'b1;
      rvalid  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: if (req) begin
          state   <= FIRST;
          a       <= addr;
          dir     <= we;
          beats   <= burst;
          cnt     <= WL;
          acc_err <= 1'b0;
        end
        WAIT: begin
          state <= cnt == '0 ? ACCESS : WAIT;
          cnt   <= cnt == '0 ? cnt : cnt - 3'd1;
        end
        ACCESS: begin
          a       <= a + 1'b1;
          beats   <= beats - 4'(beats != '0);
          acc_err <= acc_err | oor;
          cnt     <= WL;
          state   <= beats == '0 ? IDLE : FIRST;
          done    <= beats == '0;
          err     <= beats == '0 && (acc_err | oor);
          if (!dir) begin
            oor_q  <= oor;
            rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder
module tb_mem_responder;
  logic clk = 0, rst = 1, req = 0, we = 0;
  logic [17:0] addr = '0;
  logic [3:0] burst = '0;
  logic [15:0] wdata = '0;
  logic ready, wack, rvalid, done, err;
  logic [15:0] rdata;
  logic readyz, wackz, rvalidz, donez, errz;
  logic [15:0] rdataz;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .burst(burst), .wdata(wdata),
    .ready(ready), .wack(wack), .rvalid(rvalid), .rdata(rdata), .done(done), .err(err)
  );
  mem_responder #(.WAIT_CYCLES(0)) dutz (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .burst(burst), .wdata(wdata),
    .ready(readyz), .wack(wackz), .rvalid(rvalidz), .rdata(rdataz), .done(donez), .err(errz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives a request across edge N and returns at cycle N+1
  task automatic start(input logic w, input logic [17:0] a, input logic [3:0] b, input logic [15:0] d);
    req = 1; we = w; addr = a; burst = b; wdata = d;
    step();
    req = 0;
  endtask

  initial begin
    step(2);
    chk("rst_ready", ready, 1);
    chk("rst_outs", {wack, rvalid, done, err}, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    step();
    // single write then read
    start(1, 18'h00005, 0, 16'hBEEF);
    chk("w1_busy", ready, 0);
    step();
    chk("w1_nowack", wack, 0);
    step();
    chk("w1_wack", wack, 1);
    step();
    chk("w1_done", {done, err, ready}, 3'b101);
    start(0, 18'h00005, 0, 0);
    step(2);
    chk("r1_early", rvalid, 0);
    step();
    chk("r1_resp", {rvalid, done, err, ready}, 4'b1101);
    chk("r1_data", rdata, 16'hBEEF);
    step();
    chk("r1_pulse", {rvalid, done}, 0);
    chk("r1_hold", rdata, 16'hBEEF);
    // word 0 for alias and wrap checks
    start(1, 18'h00000, 0, 16'h5A5A);
    step(3);
    chk("w0_done", done, 1);
    // burst write
    start(1, 18'h00010, 3, 0);
    step(2);
    for (int k = 0; k < 4; k++) begin
      wdata = 16'h1000 + 16'(k);
      chk($sformatf("bw_wack%0d", k), wack, 1);
      step();
      if (k < 3) begin
        chk($sformatf("bw_gap%0d", k), {wack, done}, 0);
        step(2);
      end
    end
    chk("bw_done", {done, err, ready}, 3'b101);
    // burst read with an ignored request during the burst
    start(0, 18'h00010, 3, 0);
    step(3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("br_valid%0d", k), {rvalid, done}, {1'b1, k == 3});
      chk($sformatf("br_data%0d", k), rdata, 16'h1000 + 16'(k));
      if (k == 0) begin
        req = 1; we = 1; addr = 18'h00005; wdata = 16'h0000;
      end
      if (k < 3) begin
        step();
        req = 0;
        chk($sformatf("br_gap%0d", k), {rvalid, ready}, 0);
        step(2);
      end
    end
    chk("br_end", {err, ready}, 2'b01);
    step();
    // out-of-range write must not alias word 0
    start(1, 18'h20000, 0, 16'h1234);
    step(2);
    chk("oor_wack", wack, 1);
    step();
    chk("oor_wdone", {done, err}, 2'b11);
    start(0, 18'h20000, 0, 0);
    step(3);
    chk("oor_rresp", {rvalid, done, err}, 3'b111);
    chk("oor_rdata", rdata, 0);
    start(0, 18'h00000, 0, 0);
    step(3);
    chk("alias_resp", {rvalid, done, err}, 3'b110);
    chk("alias_data", rdata, 16'h5A5A);
    // wrap from top of address space
    start(0, 18'h3FFFF, 1, 0);
    step(3);
    chk("wrap_b0", {rvalid, done}, 2'b10);
    chk("wrap_d0", rdata, 0);
    step(3);
    chk("wrap_b1", {rvalid, done, err}, 3'b111);
    chk("wrap_d1", rdata, 16'h5A5A);
    // reset in the wait before beat 2
    start(0, 18'h00010, 3, 0);
    step(3);
    chk("ab_b0", rdata, 16'h1000);
    step(3);
    chk("ab_b1", rdata, 16'h1001);
    step();
    rst = 1;
    #1;
    chk("ab_ready", ready, 1);
    chk("ab_outs", {rvalid, wack, done}, 0);
    step();
    rst = 0;
    start(0, 18'h00012, 0, 0);
    step(3);
    chk("ab_after", {rvalid, done}, 2'b11);
    chk("ab_data", rdata, 16'h1002);
    start(0, 18'h00005, 0, 0);
    step(3);
    chk("ignored_req", rdata, 16'hBEEF);
    // zero-wait instance: write then read burst of three
    start(1, 18'h00020, 2, 0);
    for (int k = 0; k < 3; k++) begin
      wdata = 16'h00A0 + 16'(k);
      chk($sformatf("z_wack%0d", k), wackz, 1);
      step();
    end
    chk("z_wdone", {donez, readyz}, 2'b11);
    start(0, 18'h00020, 2, 0);
    chk("z_early", rvalidz, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("z_rv%0d", k), {rvalidz, donez}, {1'b1, k == 2});
      chk($sformatf("z_rd%0d", k), rdataz, 16'h00A0 + 16'(k));
    end
    chk("z_end", {errz, readyz}, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
